// File: rtl/sd_test_pkg.sv
// sd_test_pkg: shared FSM encoding and pattern constants for the SD self-test generator
package sd_test_pkg;
    typedef enum logic [2:0] {IDLE, WR_START, WR_WAIT, RD_START, RD_WAIT, DONE} state_t;
    localparam logic PAT_INC = 1'b0;
    localparam logic PAT_LFSR = 1'b1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int SEC_BYTES = 512;
endpackage

// File: rtl/sd_test_gen_pat_gen.sv
// sd_pat_gen: registered incrementing / Fibonacci-LFSR word sequence generator
module sd_pat_gen
    import sd_test_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter logic [15:0] SEED = 16'h0001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [15:0]       seed,
    input  logic              mode,
    input  logic              adv,
    output logic [DATA_W-1:0] word
);
    logic [15:0] cur;
    logic [15:0] nxt;

    // next sequence value: x^16+x^14+x^13+x^11+1 shifted left into bit 0, or +1
    always_comb nxt = mode == PAT_LFSR ? {cur[14:0], ^(cur & LFSR_TAPS)} : cur + 16'd1;

    // sequence state: load wins over advance so a restart always begins at the seed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= SEED;
        else if (load) cur <= seed;
        else if (adv) cur <= nxt;
    end

    assign word = cur[DATA_W-1:0];
endmodule

// File: rtl/sd_test_gen.sv
// sd_test_gen: writes SEC_NUM sectors with a pattern, reads them back and counts mismatches
module sd_test_gen
    import sd_test_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SEC_NUM = 4,
    parameter logic [31:0] START_ADDR = 32'd2000,
    parameter logic [15:0] SEED = 16'h0001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sd_init_done,
    input  logic              test_start,
    input  logic              pat_mode,
    input  logic              wr_busy,
    input  logic              wr_req,
    output logic              wr_start_en,
    output logic [31:0]       wr_sec_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              rd_busy,
    input  logic              rd_val_en,
    input  logic [DATA_W-1:0] rd_val_data,
    output logic              rd_start_en,
    output logic [31:0]       rd_sec_addr,
    output logic [15:0]       err_cnt,
    output logic              test_done,
    output logic              error_flag
);
    localparam int WPS = SEC_BYTES * 8 / DATA_W;

    state_t state;
    logic [2:0] init_sr, wbusy_sr, rbusy_sr;
    logic mode;
    logic [15:0] sec_idx, word_cnt;
    logic [DATA_W-1:0] exp_word;
    logic init_rise, init_fall, wr_fall, rd_fall, start, busy, last;
    logic wr_adv, rd_cmp, mismatch, cnt_err;
    logic [1:0] inc;
    logic [16:0] err_sum;
    logic [15:0] err_next;

    // two-flop synchronisers plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_sr  <= '0;
            wbusy_sr <= '0;
            rbusy_sr <= '0;
        end else begin
            init_sr  <= {init_sr[1:0], sd_init_done};
            wbusy_sr <= {wbusy_sr[1:0], wr_busy};
            rbusy_sr <= {rbusy_sr[1:0], rd_busy};
        end
    end

    // run control, edge events and saturating error accumulation
    always_comb begin
        init_rise = init_sr[1] & ~init_sr[2];
        init_fall = ~init_sr[1] & init_sr[2];
        wr_fall   = ~wbusy_sr[1] & wbusy_sr[2];
        rd_fall   = ~rbusy_sr[1] & rbusy_sr[2];
        busy      = state != IDLE && state != DONE;
        start     = init_rise | (test_start & ~busy & init_sr[1]);
        last      = sec_idx == 16'(SEC_NUM - 1);
        wr_adv    = wr_req && (state == WR_START || state == WR_WAIT);
        rd_cmp    = state == RD_WAIT && rd_val_en && word_cnt < 16'(WPS);
        mismatch  = rd_cmp && rd_val_data != exp_word;
        cnt_err   = state == RD_WAIT && rd_fall && word_cnt != 16'(WPS);
        inc       = {1'b0, mismatch} + {1'b0, cnt_err};
        err_sum   = {1'b0, err_cnt} + {15'd0, inc};
        err_next  = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    // main sequencer with registered command pulses and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mode        <= PAT_INC;
            sec_idx     <= '0;
            word_cnt    <= '0;
            err_cnt     <= '0;
            test_done   <= 1'b0;
            error_flag  <= 1'b1;
            wr_start_en <= 1'b0;
            rd_start_en <= 1'b0;
            wr_sec_addr <= '0;
            rd_sec_addr <= '0;
        end else begin
            wr_start_en <= 1'b0;
            rd_start_en <= 1'b0;
            if (state == RD_WAIT && rd_val_en) word_cnt <= word_cnt + 16'd1;
            if (mismatch || cnt_err) err_cnt <= err_next;
            if (start) begin
                mode       <= pat_mode;
                err_cnt    <= '0;
                test_done  <= 1'b0;
                error_flag <= 1'b1;
                sec_idx    <= '0;
                state      <= WR_START;
            end else if (init_fall && busy) begin
                state <= IDLE;
            end else begin
                case (state)
                    WR_START: begin
                        wr_start_en <= 1'b1;
                        wr_sec_addr <= START_ADDR + {16'd0, sec_idx};
                        state       <= WR_WAIT;
                    end
                    WR_WAIT: if (wr_fall) begin
                        sec_idx <= last ? 16'd0 : sec_idx + 16'd1;
                        state   <= last ? RD_START : WR_START;
                    end
                    RD_START: begin
                        rd_start_en <= 1'b1;
                        rd_sec_addr <= START_ADDR + {16'd0, sec_idx};
                        word_cnt    <= '0;
                        state       <= RD_WAIT;
                    end
                    RD_WAIT: if (rd_fall) begin
                        sec_idx <= last ? 16'd0 : sec_idx + 16'd1;
                        state   <= last ? DONE : RD_START;
                    end
                    DONE: begin
                        test_done  <= 1'b1;
                        error_flag <= err_cnt != 16'd0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    sd_pat_gen #(.DATA_W(DATA_W), .SEED(SEED)) u_wr_gen (
        .clk(clk), .rst_n(rst_n), .load(start), .seed(SEED),
        .mode(mode), .adv(wr_adv), .word(wr_data)
    );

    sd_pat_gen #(.DATA_W(DATA_W), .SEED(SEED)) u_chk_gen (
        .clk(clk), .rst_n(rst_n), .load(start), .seed(SEED),
        .mode(mode), .adv(rd_cmp), .word(exp_word)
    );
endmodule

// File: tb/tb_sd_test_gen.sv
// tb_sd_test_gen: scoreboard bench with an SD controller model for sd_test_gen
module tb_sd_test_gen;
    logic clk = 1'b0, rst_n = 1'b0, sd_init_done = 1'b0, test_start = 1'b0, pat_mode = 1'b0;
    logic wr_busy = 1'b0, wr_req = 1'b0, rd_busy = 1'b0, rd_val_en = 1'b0;
    logic [15:0] rd_val_data = 16'h0;
    logic wr_start_en, rd_start_en, test_done, error_flag;
    logic [31:0] wr_sec_addr, rd_sec_addr;
    logic [15:0] wr_data, err_cnt;

    always #5 clk = ~clk;

    sd_test_gen dut (
        .clk(clk), .rst_n(rst_n), .sd_init_done(sd_init_done), .test_start(test_start),
        .pat_mode(pat_mode), .wr_busy(wr_busy), .wr_req(wr_req), .wr_start_en(wr_start_en),
        .wr_sec_addr(wr_sec_addr), .wr_data(wr_data), .rd_busy(rd_busy), .rd_val_en(rd_val_en),
        .rd_val_data(rd_val_data), .rd_start_en(rd_start_en), .rd_sec_addr(rd_sec_addr),
        .err_cnt(err_cnt), .test_done(test_done), .error_flag(error_flag)
    );

    int n_tests = 0, n_fail = 0;
    logic [31:0] q_wa[$], q_ra[$], q_wd[$], q_res[$];
    bit wd_on = 1'b0;
    logic [15:0] first_wd[3];
    int n_wd = 0, n_wpulse = 0;
    bit m_mode = 1'b0;
    logic [31:0] bad_addr = 0, short_addr = 0, ra;
    int bad_lo = 0, bad_hi = -1, rn;
    logic [15:0] rgen = 16'h0001;
    logic done_q = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pnext(input logic [15:0] v, input bit m);
        return m ? {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]} : v + 16'd1;
    endfunction

    // monitor: pops expectations whenever the DUT presents a command, data word or result
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (wr_start_en) begin
                n_wpulse++;
                chk("wr_addr", wr_sec_addr, q_wa.size() != 0 ? q_wa.pop_front() : 32'hDEADBEEF);
            end
            if (rd_start_en)
                chk("rd_addr", rd_sec_addr, q_ra.size() != 0 ? q_ra.pop_front() : 32'hDEADBEEF);
            if (wd_on && wr_req) begin
                if (n_wd < 3) first_wd[n_wd] = wr_data;
                n_wd++;
                chk("wr_data", {16'h0, wr_data}, q_wd.size() != 0 ? q_wd.pop_front() : 32'h10000);
            end
            if (test_done && !done_q)
                chk("result", {15'h0, error_flag, err_cnt}, q_res.size() != 0 ? q_res.pop_front() : 32'h20000);
            done_q = test_done;
        end
    end

    // controller model: streams writes on request, returns readback from its own pattern copy
    initial begin
        forever begin
            @(negedge clk);
            if (wr_start_en) begin
                wr_busy = 1'b1;
                repeat (2) @(negedge clk);
                wr_req = 1'b1;
                repeat (256) @(negedge clk);
                wr_req = 1'b0;
                repeat (3) @(negedge clk);
                wr_busy = 1'b0;
            end else if (rd_start_en) begin
                ra = rd_sec_addr;
                rd_busy = 1'b1;
                repeat (2) @(negedge clk);
                rn = ra == short_addr ? 255 : 256;
                for (int i = 0; i < rn; i++) begin
                    rd_val_en = 1'b1;
                    rd_val_data = rgen ^ ((ra == bad_addr && i >= bad_lo && i <= bad_hi) ? 16'h0001 : 16'h0000);
                    rgen = pnext(rgen, m_mode);
                    @(negedge clk);
                end
                rd_val_en = 1'b0;
                repeat (3) @(negedge clk);
                rd_busy = 1'b0;
            end
        end
    end

    task automatic arm(input bit m, input logic [31:0] ba, input int lo, input int hi,
                       input logic [31:0] sa, input logic [31:0] res, input int nsec);
        logic [15:0] v;
        v = 16'h0001;
        m_mode = m;
        pat_mode = m;
        bad_addr = ba;
        bad_lo = lo;
        bad_hi = hi;
        short_addr = sa;
        rgen = 16'h0001;
        n_wd = 0;
        wd_on = nsec == 4;
        for (int s = 0; s < nsec; s++) q_wa.push_back(32'd2000 + 32'(s));
        if (nsec == 4) begin
            for (int s = 0; s < 4; s++) q_ra.push_back(32'd2000 + 32'(s));
            q_res.push_back(res);
            for (int k = 0; k < 1024; k++) begin
                q_wd.push_back({16'h0, m ? v : 16'(k + 1)});
                v = pnext(v, 1'b1);
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        test_start = 1'b1;
        @(negedge clk);
        test_start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (!test_done && t < 6000) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_in_time"}, {31'h0, t < 6000}, 32'h1);
        repeat (3) @(negedge clk);
        chk({name, "_queues_drained"}, q_wa.size() + q_ra.size() + q_wd.size() + q_res.size(), 0);
    endtask

    initial begin
        int base, t;
        repeat (3) @(negedge clk);
        chk("rst_wr_start_en", {31'h0, wr_start_en}, 0);
        chk("rst_rd_start_en", {31'h0, rd_start_en}, 0);
        chk("rst_wr_sec_addr", wr_sec_addr, 0);
        chk("rst_rd_sec_addr", rd_sec_addr, 0);
        chk("rst_wr_data", {16'h0, wr_data}, 32'h0001);
        chk("rst_err_cnt", {16'h0, err_cnt}, 0);
        chk("rst_test_done", {31'h0, test_done}, 0);
        chk("rst_error_flag", {31'h0, error_flag}, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        arm(1'b0, 0, 0, -1, 0, 32'h00000, 4);
        sd_init_done = 1'b1;
        repeat (5) @(negedge clk);
        wait_done("clean_inc");

        arm(1'b0, 32'd2001, 5, 5, 0, 32'h10001, 4);
        pulse_start();
        wait_done("corrupt_word5");

        arm(1'b1, 0, 0, -1, 0, 32'h00000, 4);
        pulse_start();
        wait_done("lfsr");
        chk("lfsr_w0", {16'h0, first_wd[0]}, 32'h0001);
        chk("lfsr_w1", {16'h0, first_wd[1]}, 32'h0002);
        chk("lfsr_w2", {16'h0, first_wd[2]}, 32'h0004);

        arm(1'b0, 0, 0, -1, 32'd2002, 32'h10001, 4);
        pulse_start();
        wait_done("short_sector");

        arm(1'b0, 32'd2003, 0, 2, 0, 32'h1FFFF, 4);
        pulse_start();
        repeat (100) @(negedge clk);
        force dut.err_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.err_cnt;
        wait_done("saturate");

        arm(1'b0, 0, 0, -1, 0, 32'h00000, 4);
        pulse_start();
        chk("restart_err_cleared", {16'h0, err_cnt}, 0);
        chk("restart_done_low", {31'h0, test_done}, 0);
        chk("restart_flag_high", {31'h0, error_flag}, 1);
        wait_done("restart");

        base = n_wpulse;
        arm(1'b0, 0, 0, -1, 0, 32'h00000, 2);
        pulse_start();
        t = 0;
        while (n_wpulse < base + 2 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (30) @(negedge clk);
        sd_init_done = 1'b0;
        t = 0;
        while (wr_busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (60) @(negedge clk);
        chk("abort_wr_pulses", n_wpulse - base, 2);
        chk("abort_done_low", {31'h0, test_done}, 0);
        chk("abort_flag_high", {31'h0, error_flag}, 1);
        chk("abort_no_read", {31'h0, rd_busy}, 0);
        chk("abort_queues", q_wa.size() + q_ra.size() + q_res.size(), 0);

        arm(1'b0, 0, 0, -1, 0, 32'h00000, 4);
        sd_init_done = 1'b1;
        repeat (5) @(negedge clk);
        wait_done("after_abort");

        arm(1'b0, 0, 0, -1, 0, 32'h00000, 4);
        pulse_start();
        wait_done("rerun");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sd_test_gen.md
Name: sd_test_gen

Overview:
- Parametrised SD card self-test data generator and checker. It sits between the SD controller's sector read/write ports and the board's status LEDs.
- It writes SEC_NUM consecutive sectors starting at START_ADDR with a selectable pattern (incrementing or LFSR), then reads them back and compares every word.
- It reports a saturating error count, a done flag and a pass/fail flag.
- It supersedes the single-sector, fixed-pattern test generator and supports restart without reset.

Parameters:
- DATA_W, 16, SD controller data word width; legal values 8 or 16.
- SEC_NUM, 4, number of consecutive sectors tested per run (1..65535).
- START_ADDR, 2000, first sector address (32-bit).
- SEED, 16'h0001, pattern start value; for LFSR mode it must be nonzero.
- Derived localparam WPS = 4096/DATA_W, words per 512-byte sector (256 for DATA_W=16).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sd_init_done  in  1  SD card initialisation complete (level)
- test_start  in  1  single-cycle request to rerun the test
- pat_mode  in  1  0 = incrementing, 1 = LFSR; sampled at run start
- wr_busy  in  1  controller write busy
- wr_req  in  1  controller requests next write word
- wr_start_en  out  1  single-cycle sector write start
- wr_sec_addr  out  32  write sector address
- wr_data  out  DATA_W  write word
- rd_busy  in  1  controller read busy
- rd_val_en  in  1  read word valid
- rd_val_data  in  DATA_W  read word
- rd_start_en  out  1  single-cycle sector read start
- rd_sec_addr  out  32  read sector address
- err_cnt  out  16  mismatch count, saturates at 16'hFFFF
- test_done  out  1  high once a run has finished, held until the next run starts
- error_flag  out  1  low only when test_done=1 and err_cnt=0

Behaviour:
- Reset values: all outputs 0, except error_flag=1 and wr_data=SEED[DATA_W-1:0]. FSM starts in IDLE.
- sd_init_done and wr_busy/rd_busy are registered internally (two flops) before edge detection. A run starts on a registered rising edge of sd_init_done, or on test_start while in IDLE or DONE with sd_init_done=1.
- Run start actions: latch pat_mode, clear err_cnt, clear test_done, set error_flag=1, reset the sector counter to 0, load both pattern generators with SEED.
- FSM states: IDLE, WR_START, WR_WAIT, RD_START, RD_WAIT, DONE.
- WR_START: for one cycle, wr_start_en=1 and wr_sec_addr=START_ADDR+sec_idx; then go to WR_WAIT.
- WR_WAIT: on the falling edge of wr_busy, increment sec_idx. If sec_idx reaches SEC_NUM, clear sec_idx and go to RD_START; otherwise go to WR_START.
- RD_START: for one cycle, rd_start_en=1 and rd_sec_addr=START_ADDR+sec_idx; clear the per-sector word count; go to RD_WAIT.
- RD_WAIT: on the falling edge of rd_busy, check the sector word count. If it is not equal to WPS, add 1 to err_cnt. Then advance to the next sector, or go to DONE after the last sector.
- DONE: test_done=1; error_flag=(err_cnt!=0). The block stays in DONE until test_start or reset.
- wr_data timing: wr_data is registered. The writer generator advances on each wr_req, so word k+1 appears one cycle after the k-th wr_req. The first word of each run is SEED. The pattern is continuous across sectors, not reset per sector.
- Incrementing pattern: next = cur+1, modulo 2^DATA_W.
- LFSR pattern: 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0. The output word is the low DATA_W bits of the LFSR.
- Checker: a second generator with the same sequence. On each rd_val_en in RD_WAIT, compare rd_val_data to the expected word, add 1 to err_cnt on mismatch, then advance the generator.
- Word-count rule: only the first WPS words of a sector are compared. Extra words still increment the word count (so the count check flags them) but are not compared.
- Ignored inputs: rd_val_en outside RD_WAIT; wr_req outside WR_START/WR_WAIT; test_start outside IDLE/DONE.
- err_cnt saturation: if a mismatch and a word-count error occur in the same cycle, err_cnt increases by 2, still saturating.
- Abort: if the registered sd_init_done falls in any busy state, go to IDLE immediately. test_done stays 0 and error_flag stays 1.
- Async reset mid-run restores all reset values at once; no start pulse is issued until the next start condition.

Decomposition:
- Package sd_test_pkg holds: FSM state encoding, pattern mode constants (PAT_INC=0, PAT_LFSR=1), LFSR tap mask 16'hB400, sector byte size 512.
- Sub-module sd_pat_gen has inputs load, seed, mode, adv and output word[DATA_W-1:0]. It is instantiated twice: once as writer, once as checker.

Test Plan:
- Default parameters, pat_mode=0, ideal controller model: sectors 2000..2003 written with words 1..1024, mod 2^16; test_done=1, error_flag=0, err_cnt=0.
- Model corrupts word 5 of sector 2001 (bit flip): err_cnt=1, error_flag=1 at DONE.
- pat_mode=1, SEED=1: the first three wr_data words are 0001, 0002, 0004, with the LFSR continuing across the boundary into sector 2001. Correct readback gives error_flag=0.
- Model delivers only 255 rd_val_en pulses for sector 2002: err_cnt=1.
- Saturation: forced err_cnt preload to FFFE via the model, then 3 mismatches → err_cnt=FFFF.
- Abort and restart: sd_init_done drops during WR_WAIT of sector 2001 → IDLE, no further start pulses. Then test_start in DONE after a clean run → err_cnt cleared, test_done low, full rerun passes.
